// File: rtl/trig_window_ctrl_if.sv
// rtl/trig_window_ctrl_if.sv - event header valid/ready channel
interface trig_window_ctrl_if #(
  parameter int TS_BITS = 48
);
  logic               evt_valid;
  logic               evt_ready;
  logic [TS_BITS-1:0] evt_ts;
  logic [1:0]         evt_idx;
  logic               evt_src;

  modport master (
    output evt_valid,
    output evt_ts,
    output evt_idx,
    output evt_src,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ts,
    input  evt_idx,
    input  evt_src,
    output evt_ready
  );
endinterface

// File: rtl/trig_window_ctrl.sv
// rtl/trig_window_ctrl.sv - TOT/software trigger to capture window sequencer
module trig_window_ctrl #(
  parameter int WIN_LEN     = 16,
  parameter int HOLDOFF_LEN = 8,
  parameter int STUCK_LEN   = 1024,
  parameter int TS_BITS     = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tot_0,
  input  logic               tot_1,
  input  logic               tot_2,
  input  logic               tot_3,
  input  logic               fvalid,
  input  logic               arm,
  input  logic               sw_trig,
  output logic               capture_en,
  trig_window_ctrl_if.master hdr,
  output logic               busy,
  output logic [15:0]        drop_cnt,
  output logic               bsum_reset
);

  localparam int SC_W = (STUCK_LEN > 2) ? $clog2(STUCK_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_HDR = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [15:0]        cnt_q;
  logic [TS_BITS-1:0] ts_q;
  logic               prev_any_q;
  logic [SC_W-1:0]    stuck_q;
  logic               bsum_q;
  logic [15:0]        drop_q;
  logic               evt_valid_q;
  logic [TS_BITS-1:0] evt_ts_q;
  logic [1:0]         evt_idx_q;
  logic               evt_src_q;

  logic               any_tot;
  logic               tot_hit;
  logic               trig_hit;
  logic               take;
  logic               hdr_done;
  logic [1:0]         tot_idx;

  assign any_tot  = fvalid & (tot_0 | tot_1 | tot_2 | tot_3);
  assign tot_hit  = arm & any_tot & ~prev_any_q;
  assign trig_hit = tot_hit | sw_trig;
  assign take     = (state_q == IDLE) & trig_hit;
  // The header is done once it was taken earlier or is being taken now.
  assign hdr_done = ~evt_valid_q | hdr.evt_ready;
  assign tot_idx  = tot_0 ? 2'd0 : (tot_1 ? 2'd1 : (tot_2 ? 2'd2 : 2'd3));

  assign hdr.evt_valid = evt_valid_q;
  assign hdr.evt_ts    = evt_ts_q;
  assign hdr.evt_idx   = evt_idx_q;
  assign hdr.evt_src   = evt_src_q;
  assign drop_cnt      = drop_q;
  assign bsum_reset    = bsum_q;

  // Free-running timestamp and one-cycle history of the qualified TOT
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      prev_any_q <= 1'b0;
    end else begin
      ts_q       <= ts_q + TS_BITS'(1);
      prev_any_q <= any_tot;
    end
  end

  // Stuck-TOT watchdog: pulse bsum_reset after STUCK_LEN consecutive high cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_q <= '0;
      bsum_q  <= 1'b0;
    end else if (any_tot) begin
      if (stuck_q == SC_W'(STUCK_LEN - 1)) begin
        stuck_q <= '0;
        bsum_q  <= 1'b1;
      end else begin
        stuck_q <= stuck_q + SC_W'(1);
        bsum_q  <= 1'b0;
      end
    end else begin
      stuck_q <= '0;
      bsum_q  <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trig_hit) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cnt_q == 16'd1) begin
          if (HOLDOFF_LEN > 0) state_d = HOLDOFF;
          else if (hdr_done)   state_d = IDLE;
          else                 state_d = WAIT_HDR;
        end
      end
      HOLDOFF: begin
        if (cnt_q == 16'd1) state_d = hdr_done ? IDLE : WAIT_HDR;
      end
      WAIT_HDR: begin
        if (evt_valid_q && hdr.evt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    capture_en = (state_q == CAPTURE);
    busy       = (state_q != IDLE);
  end

  // Shared window/holdoff down-counter, reloaded on each phase entry
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= 16'(WIN_LEN);
    end else if (state_q == CAPTURE && state_d == HOLDOFF) begin
      cnt_q <= 16'(HOLDOFF_LEN);
    end else if (cnt_q != 16'd0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  // Event header: latched at trigger, held until the handshake completes
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_ts_q    <= '0;
      evt_idx_q   <= 2'd0;
      evt_src_q   <= 1'b0;
    end else if (take) begin
      evt_valid_q <= 1'b1;
      evt_ts_q    <= ts_q;
      evt_idx_q   <= tot_hit ? tot_idx : 2'd0;
      evt_src_q   <= ~tot_hit;
    end else if (evt_valid_q && hdr.evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  // Saturating count of triggers that arrive while a window is in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (trig_hit && state_q != IDLE && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: doc/trig_window_ctrl.md
Name: trig_window_ctrl

Overview:
- Event sequencer downstream of the FIR trigger block.
- Turns the four per-sample TOT bits and the filter-valid flag into fixed-length capture windows for the waveform buffer.
- Emits one timestamped event header per window through a valid/ready handshake and counts triggers dropped while busy.
- Watches for TOT stuck high and pulses the trigger block's bsum_reset to recover the rolling baseline.

Parameters:
WIN_LEN, 16, cycles capture_en is held high per event (1..65535)
HOLDOFF_LEN, 8, dead cycles after window before re-arm (0 = none)
STUCK_LEN, 1024, consecutive TOT-high cycles that force a bsum_reset pulse (>=2)
TS_BITS, 48, timestamp counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tot_0..tot_3  in  1 each  time-over-threshold bits, sample 0 earliest
fvalid  in  1  filter output valid; TOTs ignored when low
arm  in  1  level enable for TOT triggering
sw_trig  in  1  software trigger pulse, honoured regardless of arm/fvalid
capture_en  out  1  waveform buffer write enable
evt_valid  out  1  event header valid
evt_ready  in  1  downstream accepts header
evt_ts  out  TS_BITS  timestamp of the trigger cycle
evt_idx  out  2  lowest i with tot_i set at trigger (0 for sw)
evt_src  out  1  0 = TOT, 1 = software
busy  out  1  state != IDLE
drop_cnt  out  16  saturating count of triggers lost while busy
bsum_reset  out  1  one-cycle baseline-sum reset pulse

Behaviour:
- Reset (sync, high): all outputs 0, ts = 0, state IDLE, prev_any = 0, all counters 0. Reset mid-window aborts the window and does not emit a header.
- ts increments every cycle and wraps modulo 2^TS_BITS.
- any_tot = fvalid && (tot_0|tot_1|tot_2|tot_3). prev_any is any_tot registered every cycle in every state.
- tot_hit = arm && any_tot && !prev_any (rising edge only).
- trig_hit = tot_hit || sw_trig. If both occur in the same cycle, the TOT trigger wins: evt_src = 0 and evt_idx comes from the TOTs.
- States: IDLE, CAPTURE, HOLDOFF, WAIT_HDR.
- IDLE, trig_hit in cycle T:
  - Cycle T+1: state CAPTURE, capture_en = 1, evt_valid = 1.
  - evt_ts = ts at cycle T; evt_idx and evt_src latched from cycle T.
  - Window counter loads WIN_LEN.
- CAPTURE:
  - capture_en is high exactly for cycles T+1..T+WIN_LEN.
  - After the last window cycle, go to HOLDOFF if HOLDOFF_LEN > 0.
  - If HOLDOFF_LEN = 0, go to IDLE when the header has been accepted, else WAIT_HDR.
- HOLDOFF: lasts HOLDOFF_LEN cycles with capture_en = 0, then goes to IDLE (header accepted) or WAIT_HDR.
- WAIT_HDR: wait for the handshake; go to IDLE in the cycle after evt_valid && evt_ready.
- Re-arm timing: the earliest next trigger is cycle T+WIN_LEN+HOLDOFF_LEN+1, in IDLE.
- Handshake:
  - Header is accepted in a cycle where evt_valid && evt_ready; evt_valid drops the next cycle.
  - Header fields stay stable while evt_valid is high. evt_ready is allowed in any state.
  - evt_valid is not re-asserted until a new trigger is taken.
- Drops: trig_hit in any state other than IDLE increments drop_cnt, saturating at 0xFFFF. The drop counter is cleared only by reset.
- arm deasserted mid-window: the window and header complete normally, and no further TOT triggers are taken.
- Stuck detection (independent of state):
  - stuck_cnt increments each cycle any_tot = 1 and clears when any_tot = 0.
  - When stuck_cnt reaches STUCK_LEN - 1 with any_tot = 1, bsum_reset = 1 for that single cycle (registered output, next cycle) and stuck_cnt clears.
  - A TOT still high afterwards repeats the pulse every STUCK_LEN cycles.
- busy = (state != IDLE), registered together with the state.

Test Plan:
- Defaults, arm=1, fvalid=1; tot_2 rises at cycle T where ts=100, evt_ready=1 -> capture_en high T+1..T+16; header ts=100, idx=2, src=0 at T+1; busy low from T+25; drop_cnt=0.
- Hold tot_1 high 3 cycles, then toggle tot_0 low/high during the window -> exactly one event; each rising edge inside CAPTURE/HOLDOFF adds 1 to drop_cnt; no second header.
- evt_ready=0 until T+40 -> state WAIT_HDR from T+25; evt_valid and header held stable; accept at T+40 -> IDLE at T+41; a trigger at T+41 accepted.
- sw_trig and tot_3 rising in the same cycle -> src=0, idx=3; sw_trig alone with arm=0, fvalid=0 -> src=1, idx=0, full 16-cycle window.
- STUCK_LEN=8, tot_0 held high 20 cycles with fvalid=1 -> bsum_reset single-cycle pulses 8 cycles apart (two pulses); releasing TOT for one cycle restarts the count.
- Assert reset at T+5 of a window -> next cycle capture_en=0, evt_valid=0, busy=0, ts=0, drop_cnt=0.
